// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, datapath widths and the S1 payload layout.
// Imported by decode and by the shift execute stage.
package alu_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = $clog2(XLEN);
    localparam int TAG_W   = 5;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef struct packed {
        logic [1:0]         op;
        logic [XLEN-1:0]    a;
        logic [SHAMT_W-1:0] sh;
        logic [TAG_W-1:0]   tag;
    } s1_payload_t;

    function automatic logic [XLEN-1:0] bitReverse(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) begin
            r[i] = v[XLEN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_exec_stage_if.sv
// Decode-side and writeback-side valid/ready channels of the shift execute stage.
// The stage itself is the slave; decode/writeback (or a bench) hold the master view.
interface shift_exec_stage_if;
    import alu_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_op;
    logic [XLEN-1:0]    in_a;
    logic [XLEN-1:0]    in_b;
    logic [TAG_W-1:0]   in_tag;

    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_result;
    logic               out_zero;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_tag
    );

endinterface

// File: rtl/shift_core.sv
// Combinational shifter: one left-shift core serves SLL directly and SRL/SRA through
// bit reversal on both sides; SRA then ORs in the sign fill.
module shift_core
    import alu_pkg::*;
(
    input  logic [XLEN-1:0]    i_a,
    input  logic [SHAMT_W-1:0] i_sh,
    input  logic [1:0]         i_op,
    output logic [XLEN-1:0]    o_result
);

    logic [XLEN-1:0] w_coreIn;
    logic [XLEN-1:0] w_coreOut;
    logic [XLEN-1:0] w_rightOut;
    logic [XLEN-1:0] w_signFill;

    always_comb begin
        w_coreIn   = (i_op == OP_SLL) ? i_a : bitReverse(i_a);
        w_coreOut  = w_coreIn << i_sh;
        w_rightOut = bitReverse(w_coreOut);
        // Ones in exactly the top sh bits, i.e. the positions SRL zero-filled.
        w_signFill = i_a[XLEN-1] ? ~({XLEN{1'b1}} >> i_sh) : '0;
        case (i_op)
            OP_SLL:  o_result = w_coreOut;
            OP_SRL:  o_result = w_rightOut;
            OP_SRA:  o_result = w_rightOut | w_signFill;
            default: o_result = i_a;
        endcase
    end

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage execute wrapper for the shift path: S1 registers operands, S2 registers the
// shifted result; valid/ready on both sides with full backpressure and synchronous flush.
module shift_exec_stage
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    shift_exec_stage_if.slave bus
);

    logic            r_s1Valid;
    s1_payload_t     r_s1;
    logic            r_s2Valid;
    logic [XLEN-1:0] r_s2Result;
    logic            r_s2Zero;
    logic [TAG_W-1:0] r_s2Tag;

    logic            w_s2Adv;
    logic            w_s1Adv;
    logic            w_inReady;
    logic [XLEN-1:0] w_result;

    // An empty stage always advances, so bubbles collapse instead of stalling upstream.
    assign w_s2Adv   = !r_s2Valid || bus.out_ready;
    assign w_s1Adv   = !r_s1Valid || w_s2Adv;
    assign w_inReady = w_s1Adv && !i_flush && !rst;

    shift_core u_core (
        .i_a      (r_s1.a),
        .i_sh     (r_s1.sh),
        .i_op     (r_s1.op),
        .o_result (w_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid  <= 1'b0;
            r_s1       <= '0;
            r_s2Valid  <= 1'b0;
            r_s2Result <= '0;
            r_s2Zero   <= 1'b1;
            r_s2Tag    <= '0;
        end else begin
            if (w_s1Adv) begin
                r_s1Valid <= bus.in_valid && w_inReady;
                r_s1.op   <= bus.in_op;
                r_s1.a    <= bus.in_a;
                r_s1.sh   <= bus.in_b[SHAMT_W-1:0];
                r_s1.tag  <= bus.in_tag;
            end
            if (w_s2Adv) begin
                r_s2Valid  <= r_s1Valid;
                r_s2Result <= w_result;
                r_s2Zero   <= (w_result == '0);
                r_s2Tag    <= r_s1.tag;
            end
            // Flush wins over the advances above; an output taken this edge is still delivered.
            if (i_flush) begin
                r_s1Valid <= 1'b0;
                r_s2Valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = w_inReady;
    assign bus.out_valid  = r_s2Valid;
    assign bus.out_result = r_s2Result;
    assign bus.out_zero   = r_s2Zero;
    assign bus.out_tag    = r_s2Tag;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage: directed vectors with hand-computed results,
// backpressure/flush/reset scenarios, and a randomized stream against a transaction scoreboard.
module tb_shift_exec_stage;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   outCount = 0;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic [4:0]  tag;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;
    logic [31:0] monRes;

    shift_exec_stage_if bus();

    shift_exec_stage dut (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] refShift(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            2'b00:   return a << sh;
            2'b01:   return a >> sh;
            2'b10:   return $unsigned($signed(a) >>> sh);
            default: return a;
        endcase
    endfunction

    // Transaction scoreboard, sampled mid-cycle so it sees exactly what fires at the next edge.
    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_out", 64'(1), 64'(0));
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("scoreboard", 64'({bus.out_result, bus.out_zero, bus.out_tag}),
                                64'(monExp));
                end
                outCount++;
            end
            if (flush) expQ.delete();
            if (bus.in_valid && bus.in_ready) begin
                monRes = refShift(bus.in_op, bus.in_a, bus.in_b);
                expQ.push_back({monRes, monRes == 32'h0, bus.in_tag});
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] tag);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (bus.in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) checkOutput("stim_timeout", 64'(0), 64'(1));
    endtask

    task automatic runDirected(input string name, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] tag,
                               input logic [31:0] expected);
        applyStimulus(op, a, b, tag);
        bus.in_valid = 1'b0;
        checkOutput({name, "_lat1"}, 64'(bus.out_valid), 64'(0));
        @(posedge clk); #1;
        checkOutput({name, "_valid"}, 64'(bus.out_valid), 64'(1));
        checkOutput({name, "_result"}, 64'(bus.out_result), 64'(expected));
        checkOutput({name, "_zero"}, 64'(bus.out_zero), 64'(expected == 32'h0));
        checkOutput({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int startCount;
        bit fired;

        bus.in_valid  = 1'b1;
        bus.in_op     = OP_SLL;
        bus.in_a      = 32'hDEAD_BEEF;
        bus.in_b      = 32'h3;
        bus.in_tag    = 5'd7;
        bus.out_ready = 1'b1;

        // Reset held two cycles with an op being offered.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checkOutput("rst_in_ready", 64'(bus.in_ready), 64'(0));
            checkOutput("rst_out_valid", 64'(bus.out_valid), 64'(0));
            checkOutput("rst_out_result", 64'(bus.out_result), 64'(0));
            checkOutput("rst_out_zero", 64'(bus.out_zero), 64'(1));
            checkOutput("rst_out_tag", 64'(bus.out_tag), 64'(0));
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;

        runDirected("sll31",   OP_SLL,  32'h0000_0001, 32'd31,        5'd1, 32'h8000_0000);
        runDirected("srl4",    OP_SRL,  32'h8000_0000, 32'd4,         5'd2, 32'h0800_0000);
        runDirected("sra4",    OP_SRA,  32'h8000_0000, 32'd4,         5'd3, 32'hF800_0000);
        runDirected("pass",    OP_PASS, 32'h1234_5678, 32'd9,         5'd4, 32'h1234_5678);
        runDirected("sll_hi",  OP_SLL,  32'hFFFF_FFFF, 32'h0000_0020, 5'd5, 32'hFFFF_FFFF);
        runDirected("zero",    OP_SLL,  32'h0000_0100, 32'd24,        5'd6, 32'h0000_0000);
        runDirected("sra31",   OP_SRA,  32'h8000_0000, 32'd31,        5'd7, 32'hFFFF_FFFF);
        runDirected("sll31b",  OP_SLL,  32'hFFFF_FFFF, 32'd31,        5'd8, 32'h8000_0000);
        runDirected("srl0",    OP_SRL,  32'hF000_000F, 32'hFFFF_FFE0, 5'd9, 32'hF000_000F);
        runDirected("sra_pos", OP_SRA,  32'h7000_0000, 32'd8,         5'd10, 32'h0070_0000);

        // Backpressure: 8-op stream, writeback stalls 5 cycles after the third edge.
        startCount = outCount;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    applyStimulus(2'(i % 4), 32'hA5C3_0F00 ^ (32'(i) * 32'h0111_1111),
                                  32'(i * 5), 5'(i));
                end
                bus.in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                checkOutput("bp_in_ready_held", 64'(bus.in_ready), 64'(0));
                for (int k = 1; k < 8; k++) begin
                    checkOutput("bp_out_valid", 64'(bus.out_valid), 64'(1));
                    checkOutput("bp_out_tag", 64'(bus.out_tag), 64'(k));
                    bus.out_ready = 1'b1;
                    @(posedge clk); #1;
                end
            end
        join
        checkOutput("bp_empty_after", 64'(bus.out_valid), 64'(0));
        checkOutput("bp_queue_drained", 64'(expQ.size()), 64'(0));
        checkOutput("bp_out_count", 64'(outCount - startCount), 64'(8));

        // Flush with two ops in flight and a third offered in the flush cycle.
        applyStimulus(OP_SLL, 32'h0000_00FF, 32'd4, 5'd10);
        applyStimulus(OP_SRL, 32'hFF00_0000, 32'd4, 5'd11);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_op    = OP_SRA;
        bus.in_a     = 32'hF000_0000;
        bus.in_b     = 32'd8;
        bus.in_tag   = 5'd12;
        #1;
        checkOutput("fl_in_ready", 64'(bus.in_ready), 64'(0));
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("fl_out_valid", 64'(bus.out_valid), 64'(0));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checkOutput("fl_not_taken", 64'(bus.out_valid), 64'(0));
        @(posedge clk); #1;
        checkOutput("fl_next_valid", 64'(bus.out_valid), 64'(1));
        checkOutput("fl_next_result", 64'(bus.out_result), 64'(32'hFFF0_0000));
        checkOutput("fl_next_tag", 64'(bus.out_tag), 64'(12));
        @(posedge clk); #1;

        // Reset while an op sits in S1: nothing may emerge.
        applyStimulus(OP_SLL, 32'h0000_0003, 32'd1, 5'd3);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("mid_rst_valid", 64'(bus.out_valid), 64'(0));
        @(posedge clk); #1;
        checkOutput("mid_rst_valid2", 64'(bus.out_valid), 64'(0));
        checkOutput("mid_rst_zero", 64'(bus.out_zero), 64'(1));

        // Random stream with random valid/ready and occasional flush.
        startCount = outCount;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            fired = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (!bus.in_valid || fired) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_op    = 2'($urandom_range(0, 3));
                bus.in_a     = ($urandom_range(0, 7) == 0) ? 32'h0000_0100 : $urandom;
                bus.in_b     = $urandom;
                bus.in_tag   = 5'($urandom_range(0, 31));
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 63) == 0);
        end
        bus.in_valid  = 1'b0;
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("rand_drained", 64'(expQ.size()), 64'(0));
        checkOutput("rand_idle", 64'(bus.out_valid), 64'(0));
        checkOutput("rand_activity", 64'((outCount - startCount) > 500), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
